// File: rtl/cp0_regfile_pkg.sv
// Shared CPU package for the CP0 register file.
// Holds the CP0 {rd,sel} address constants, the exception code enumeration
// and the packed layouts of the Status and Cause registers.
package cp0_regfile_pkg;

  localparam logic [7:0] CP0_ADDR_BADVADDR = {5'd8,  3'd0};
  localparam logic [7:0] CP0_ADDR_COUNT    = {5'd9,  3'd0};
  localparam logic [7:0] CP0_ADDR_COMPARE  = {5'd11, 3'd0};
  localparam logic [7:0] CP0_ADDR_STATUS   = {5'd12, 3'd0};
  localparam logic [7:0] CP0_ADDR_CAUSE    = {5'd13, 3'd0};
  localparam logic [7:0] CP0_ADDR_EPC      = {5'd14, 3'd0};
  localparam logic [7:0] CP0_ADDR_PRID     = {5'd15, 3'd0};
  localparam logic [7:0] CP0_ADDR_CONFIG   = {5'd16, 3'd0};

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12,
    EXC_TR   = 5'd13
  } exc_code_t;

  typedef struct packed {
    logic [8:0] rsvd_hi;   // 31:23
    logic       bev;       // 22
    logic [5:0] rsvd_mid;  // 21:16
    logic [7:0] im;        // 15:8
    logic [5:0] rsvd_lo;   // 7:2
    logic       exl;       // 1
    logic       ie;        // 0
  } cp0_status_t;

  typedef struct packed {
    logic        bd;        // 31
    logic        ti;        // 30
    logic [13:0] rsvd_hi;   // 29:16
    logic [7:0]  ip;        // 15:8
    logic        rsvd_mid;  // 7
    logic [4:0]  exc_code;  // 6:2
    logic [1:0]  rsvd_lo;   // 1:0
  } cp0_cause_t;

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer.
// Count advances once every second clock using a toggle bit; an MTC0 to
// Count loads the value and restarts the toggle. Compare is plain storage.
// Optional macro CP0_TIMER_INT_EN: TI becomes a sticky Count==Compare flag
// cleared by an MTC0 to Compare; without it TI is tied to 0.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   count_we, compare_we  qualified MTC0 strobes for Count / Compare
//   wdata                 MTC0 data
//   count, compare        register contents
//   ti                    timer interrupt flag (Cause.TI)
module cp0_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  logic tick_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= 32'd0;
      compare <= 32'd0;
      tick_q  <= 1'b0;
    end else begin
      // A Count write beats the increment and restarts the half-rate phase.
      if (count_we) begin
        count  <= wdata;
        tick_q <= 1'b0;
      end else begin
        tick_q <= ~tick_q;
        if (tick_q) count <= count + 32'd1;
      end
      if (compare_we) compare <= wdata;
    end
  end

`ifdef CP0_TIMER_INT_EN
  always_ff @(posedge clk) begin
    if (reset)                  ti <= 1'b0;
    else if (compare_we)        ti <= 1'b0;   // clear wins over a same-cycle match
    else if (count == compare)  ti <= 1'b1;
  end
`else
  assign ti = 1'b0;
`endif

endmodule

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file and SPU CP0 read/write responder.
// Holds BadVAddr, Count, Compare, Status, Cause, EPC, PRId and Config,
// applies exception / ERET events from commit and reports the EPC redirect
// target, Status.EXL and the interrupt request.
// Optional macro CP0_TIMER_INT_EN (in cp0_timer): Count==Compare timer
// interrupt feeding Cause.TI and IP7.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   cp0_we/cp0_addr/cp0_wdata       MTC0 port, cp0_addr = {rd,sel}
//   cp0_rdata                       MFC0 data, combinational from cp0_addr
//   exc_valid/exc_code/exc_pc/exc_bd, exc_badvaddr_valid/exc_badvaddr
//                                   committed exception event
//   eret_valid                      committed ERET
//   int_i                           level-sensitive hardware interrupts
//   epc_o, status_exl_o, int_pending_o  outputs to commit
module cp0_regfile
  import cp0_regfile_pkg::*;
#(
  parameter logic [31:0] PRID_VALUE   = 32'h0001_8003,
  parameter logic [31:0] CONFIG_VALUE = 32'h8000_0003
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cp0_we,
  input  logic [7:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic        exc_badvaddr_valid,
  input  logic [31:0] exc_badvaddr,
  input  logic        eret_valid,
  input  logic [5:0]  int_i,
  output logic [31:0] epc_o,
  output logic        status_exl_o,
  output logic        int_pending_o
);

  logic [31:0] badvaddr, epc, count, compare;
  logic [7:0]  status_im;
  logic        status_exl, status_ie;
  logic        cause_bd, ti;
  exc_code_t   cause_exc;
  logic [5:0]  int_q;
  logic [1:0]  cause_ipsw;
  logic [7:0]  cause_ip;
  logic        wr_ok;
  cp0_status_t status_rd;
  cp0_cause_t  cause_rd;

  // An exception flushes the instruction carrying any MTC0.
  assign wr_ok = cp0_we & ~exc_valid;

  cp0_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .count_we   (wr_ok && (cp0_addr == CP0_ADDR_COUNT)),
    .compare_we (wr_ok && (cp0_addr == CP0_ADDR_COMPARE)),
    .wdata      (cp0_wdata),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      badvaddr   <= 32'd0;
      epc        <= 32'd0;
      status_im  <= 8'd0;
      status_exl <= 1'b0;
      status_ie  <= 1'b0;
      cause_bd   <= 1'b0;
      cause_exc  <= EXC_INT;
      cause_ipsw <= 2'd0;
      int_q      <= 6'd0;
    end else begin
      int_q <= int_i;
      if (exc_valid) begin
        // A nested exception keeps the original return point.
        if (!status_exl) begin
          epc      <= exc_bd ? exc_pc - 32'd4 : exc_pc;
          cause_bd <= exc_bd;
        end
        cause_exc  <= exc_code_t'(exc_code);
        status_exl <= 1'b1;
        if (exc_badvaddr_valid) badvaddr <= exc_badvaddr;
      end else begin
        if (wr_ok && (cp0_addr == CP0_ADDR_STATUS)) begin
          status_im  <= cp0_wdata[15:8];
          status_ie  <= cp0_wdata[0];
          status_exl <= cp0_wdata[1] & ~eret_valid;
        end else if (eret_valid) begin
          status_exl <= 1'b0;
        end
        if (wr_ok && (cp0_addr == CP0_ADDR_CAUSE)) cause_ipsw <= cp0_wdata[9:8];
        if (wr_ok && (cp0_addr == CP0_ADDR_EPC))   epc        <= cp0_wdata;
      end
    end
  end

  assign cause_ip = {int_q[5] | ti, int_q[4:0], cause_ipsw};

  always_comb begin
    status_rd      = '0;
    status_rd.bev  = 1'b1;
    status_rd.im   = status_im;
    status_rd.exl  = status_exl;
    status_rd.ie   = status_ie;
    cause_rd          = '0;
    cause_rd.bd       = cause_bd;
    cause_rd.ti       = ti;
    cause_rd.ip       = cause_ip;
    cause_rd.exc_code = cause_exc;
  end

  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_addr)
      CP0_ADDR_BADVADDR: cp0_rdata = badvaddr;
      CP0_ADDR_COUNT:    cp0_rdata = count;
      CP0_ADDR_COMPARE:  cp0_rdata = compare;
      CP0_ADDR_STATUS:   cp0_rdata = status_rd;
      CP0_ADDR_CAUSE:    cp0_rdata = cause_rd;
      CP0_ADDR_EPC:      cp0_rdata = epc;
      CP0_ADDR_PRID:     cp0_rdata = PRID_VALUE;
      CP0_ADDR_CONFIG:   cp0_rdata = CONFIG_VALUE;
      default:           cp0_rdata = 32'd0;
    endcase
  end

  assign epc_o         = epc;
  assign status_exl_o  = status_exl;
  assign int_pending_o = status_ie & ~status_exl & (|(cause_ip & status_im));

endmodule

// File: tb/tb_cp0_regfile.sv
module tb_cp0_regfile;

  localparam logic [7:0] A_BADV = {5'd8, 3'd0};
  localparam logic [7:0] A_CNT  = {5'd9, 3'd0};
  localparam logic [7:0] A_CMP  = {5'd11, 3'd0};
  localparam logic [7:0] A_STAT = {5'd12, 3'd0};
  localparam logic [7:0] A_CAUS = {5'd13, 3'd0};
  localparam logic [7:0] A_EPC  = {5'd14, 3'd0};
  localparam logic [7:0] A_PRID = {5'd15, 3'd0};
  localparam logic [7:0] A_CONF = {5'd16, 3'd0};
  localparam logic [7:0] A_UNMP = {5'd20, 3'd0};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cp0_we = 1'b0;
  logic [7:0]  cp0_addr = 8'd0;
  logic [31:0] cp0_wdata = 32'd0;
  logic [31:0] cp0_rdata;
  logic        exc_valid = 1'b0;
  logic [4:0]  exc_code = 5'd0;
  logic [31:0] exc_pc = 32'd0;
  logic        exc_bd = 1'b0;
  logic        exc_badvaddr_valid = 1'b0;
  logic [31:0] exc_badvaddr = 32'd0;
  logic        eret_valid = 1'b0;
  logic [5:0]  int_i = 6'd0;
  logic [31:0] epc_o;
  logic        status_exl_o;
  logic        int_pending_o;

  int passed = 0;
  int total  = 0;

  // Reference model state: architectural values, Count as base + elapsed/2.
  logic [31:0] m_status, m_epc, m_badv, m_base, m_cyc, m_cmp;
  logic [1:0]  m_ipsw;
  logic        m_bd, m_ti;
  logic [4:0]  m_code;
  logic [5:0]  m_intq;

  cp0_regfile dut (
    .clk(clk), .reset(reset), .cp0_we(cp0_we), .cp0_addr(cp0_addr),
    .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata), .exc_valid(exc_valid),
    .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
    .exc_badvaddr_valid(exc_badvaddr_valid), .exc_badvaddr(exc_badvaddr),
    .eret_valid(eret_valid), .int_i(int_i), .epc_o(epc_o),
    .status_exl_o(status_exl_o), .int_pending_o(int_pending_o)
  );

  always #10 clk = ~clk;

  function automatic logic [31:0] m_count();
    return m_base + (m_cyc >> 1);
  endfunction

  function automatic logic [7:0] m_ip();
    return {m_intq[5] | m_ti, m_intq[4:0], m_ipsw};
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a);
    case (a)
      A_BADV:  return m_badv;
      A_CNT:   return m_count();
      A_CMP:   return m_cmp;
      A_STAT:  return m_status;
      A_CAUS:  return {m_bd, m_ti, 14'd0, m_ip(), 1'b0, m_code, 2'b00};
      A_EPC:   return m_epc;
      A_PRID:  return 32'h0001_8003;
      A_CONF:  return 32'h8000_0003;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_pending();
    return m_status[0] & ~m_status[1] & (|(m_ip() & m_status[15:8]));
  endfunction

  task automatic model_edge();
    logic [31:0] cnt_now;
    logic        load, cmp_wr, match;
    cnt_now = m_count();
    match   = (cnt_now == m_cmp);
    load    = 1'b0;
    cmp_wr  = 1'b0;
    if (reset) begin
      m_status = 32'h0040_0000; m_epc = 0; m_badv = 0; m_base = 0; m_cyc = 0;
      m_cmp = 0; m_ipsw = 0; m_bd = 0; m_ti = 0; m_code = 0; m_intq = 0;
    end else begin
      if (exc_valid) begin
        if (!m_status[1]) begin
          m_epc = exc_bd ? exc_pc - 32'd4 : exc_pc;
          m_bd  = exc_bd;
        end
        m_code = exc_code;
        m_status[1] = 1'b1;
        if (exc_badvaddr_valid) m_badv = exc_badvaddr;
      end else begin
        if (cp0_we) begin
          case (cp0_addr)
            A_STAT: m_status = (m_status & ~32'h0000_FF03) | (cp0_wdata & 32'h0000_FF03);
            A_CAUS: m_ipsw = cp0_wdata[9:8];
            A_EPC:  m_epc = cp0_wdata;
            A_CNT:  begin m_base = cp0_wdata; load = 1'b1; end
            A_CMP:  begin m_cmp = cp0_wdata; cmp_wr = 1'b1; end
            default: ;
          endcase
        end
        if (eret_valid) m_status[1] = 1'b0;
      end
      m_cyc = load ? 32'd0 : m_cyc + 32'd1;
`ifdef CP0_TIMER_INT_EN
      if (cmp_wr) m_ti = 1'b0;
      else if (match) m_ti = 1'b1;
`else
      if (cmp_wr && match) m_ti = 1'b0;
`endif
      m_intq = int_i;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    cp0_we = 1'b0; exc_valid = 1'b0; eret_valid = 1'b0; exc_badvaddr_valid = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, ".epc_o"}, epc_o, m_epc);
    chk({tag, ".exl"}, {31'd0, status_exl_o}, {31'd0, m_status[1]});
    chk({tag, ".pend"}, {31'd0, int_pending_o}, {31'd0, m_pending()});
  endtask

  task automatic chk_read(input string tag, input logic [7:0] a);
    cp0_addr = a;
    #1;
    chk(tag, cp0_rdata, m_read(a));
  endtask

  task automatic chk_all(input string tag);
    cp0_we = 1'b0;
    chk_read({tag, ".badv"}, A_BADV);
    chk_read({tag, ".cnt"},  A_CNT);
    chk_read({tag, ".cmp"},  A_CMP);
    chk_read({tag, ".stat"}, A_STAT);
    chk_read({tag, ".caus"}, A_CAUS);
    chk_read({tag, ".epc"},  A_EPC);
    chk_read({tag, ".prid"}, A_PRID);
    chk_read({tag, ".unmp"}, A_UNMP);
    chk_outs(tag);
  endtask

  task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
    cp0_we = 1'b1; cp0_addr = a; cp0_wdata = d;
    tick();
  endtask

  task automatic read_lit(input string tag, input logic [7:0] a, input logic [31:0] exp);
    cp0_addr = a;
    #1;
    chk(tag, cp0_rdata, exp);
  endtask

  logic [7:0] addr_tbl [10];

  initial begin
    addr_tbl = '{A_BADV, A_CNT, A_CMP, A_STAT, A_CAUS, A_EPC, A_PRID, A_CONF, A_UNMP, 8'h01};

    // Reset values
    reset = 1'b1;
    tick(); tick();
    read_lit("rst.status", A_STAT, 32'h0040_0000);
    read_lit("rst.prid",   A_PRID, 32'h0001_8003);
    read_lit("rst.config", A_CONF, 32'h8000_0003);
    read_lit("rst.cause",  A_CAUS, 32'h0000_0000);
    read_lit("rst.epc",    A_EPC,  32'h0000_0000);
    read_lit("rst.count",  A_CNT,  32'h0000_0000);
    read_lit("rst.unmap",  A_UNMP, 32'h0000_0000);
    reset = 1'b0;

    // Status write: masked fields, same-cycle read sees old value
    cp0_we = 1'b1; cp0_addr = A_STAT; cp0_wdata = 32'hFFFF_FFFF;
    #1;
    chk("stat.samecyc", cp0_rdata, 32'h0040_0000);
    tick();
    read_lit("stat.new", A_STAT, 32'h0040_FF03);
    chk_all("stat");
    mtc0(A_STAT, 32'h0000_0000);
    mtc0(A_PRID, 32'hDEAD_BEEF);
    mtc0(A_BADV, 32'hDEAD_BEEF);
    chk_all("ro");

    // Exception in delay slot
    exc_valid = 1'b1; exc_code = 5'd4; exc_pc = 32'hBFC0_0100; exc_bd = 1'b1;
    exc_badvaddr_valid = 1'b1; exc_badvaddr = 32'h0000_0003;
    tick();
    chk("exc1.epc", epc_o, 32'hBFC0_00FC);
    chk("exc1.exl", {31'd0, status_exl_o}, 32'd1);
    read_lit("exc1.badv", A_BADV, 32'h0000_0003);
    cp0_addr = A_CAUS; #1;
    chk("exc1.bd_code", {cp0_rdata[31], 24'd0, cp0_rdata[6:2]}, {1'b1, 24'd0, 5'd4});
    chk_all("exc1");
    exc_valid = 1'b1; exc_code = 5'd12; exc_pc = 32'h8000_0000; exc_bd = 1'b0;
    tick();
    chk("exc2.epc", epc_o, 32'hBFC0_00FC);
    chk_all("exc2");
    eret_valid = 1'b1;
    tick();
    chk("eret.exl", {31'd0, status_exl_o}, 32'd0);

    // Exception beats a same-cycle EPC write
    exc_valid = 1'b1; exc_code = 5'd8; exc_pc = 32'h0040_0020; exc_bd = 1'b0;
    cp0_we = 1'b1; cp0_addr = A_EPC; cp0_wdata = 32'h1234_5678;
    tick();
    chk("excwe.epc", epc_o, 32'h0040_0020);
    chk_all("excwe");
    // ERET with Status write: write applies but EXL clears
    eret_valid = 1'b1; cp0_we = 1'b1; cp0_addr = A_STAT; cp0_wdata = 32'h0000_0003;
    tick();
    read_lit("eretwe.stat", A_STAT, 32'h0040_0001);

    // Hardware interrupt path
    mtc0(A_STAT, 32'h0000_0401);
    int_i = 6'b000001;
    tick();
    chk_outs("int1");
    tick();
    chk("int.pend", {31'd0, int_pending_o}, 32'd1);
    mtc0(A_STAT, 32'h0000_0403);
    chk("int.exl_mask", {31'd0, int_pending_o}, 32'd0);
    int_i = 6'd0;
    mtc0(A_CAUS, 32'hFFFF_FFFF);
    chk_all("swint");

    // Count wrap
    mtc0(A_CNT, 32'hFFFF_FFFF);
    read_lit("wrap.load", A_CNT, 32'hFFFF_FFFF);
    tick(); tick();
    read_lit("wrap.zero", A_CNT, 32'h0000_0000);

    // Reset mid-operation beats a pending exception
    reset = 1'b1; exc_valid = 1'b1; exc_pc = 32'h1111_1110; exc_bd = 1'b0;
    tick();
    reset = 1'b0;
    chk("midrst.exl", {31'd0, status_exl_o}, 32'd0);
    chk("midrst.epc", epc_o, 32'd0);
    chk_all("midrst");

`ifdef CP0_TIMER_INT_EN
    mtc0(A_CMP, 32'd10);
    mtc0(A_CNT, 32'd0);
    mtc0(A_STAT, 32'h0000_8001);
    begin
      int n = 0;
      while (!int_pending_o && n < 40) begin tick(); n++; end
      chk("ti.pend", {31'd0, int_pending_o}, 32'd1);
    end
    cp0_addr = A_CAUS; #1;
    chk("ti.set", {31'd0, cp0_rdata[30]}, 32'd1);
    chk_all("ti");
    mtc0(A_CMP, 32'd1000);
    cp0_addr = A_CAUS; #1;
    chk("ti.clr", {31'd0, cp0_rdata[30]}, 32'd0);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      reset      = ($urandom_range(0, 99) == 0);
      cp0_we     = $urandom_range(0, 1);
      cp0_addr   = addr_tbl[$urandom_range(0, 9)];
      cp0_wdata  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : $urandom;
      exc_valid  = ($urandom_range(0, 9) == 0);
      exc_code   = 5'($urandom);
      exc_pc     = $urandom;
      exc_bd     = $urandom_range(0, 1);
      exc_badvaddr_valid = $urandom_range(0, 1);
      exc_badvaddr = $urandom;
      eret_valid = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) int_i = 6'($urandom);
      tick();
      chk_read("rnd.read", addr_tbl[$urandom_range(0, 9)]);
      chk_outs("rnd");
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
